// File: rtl/mem_arbiter_pkg.sv
// Shared types, requester IDs, length codes and FSM states for the memory-port arbiter.
package mem_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    REQ_IF = 2'd0,
    REQ_LB = 2'd1,
    REQ_ST = 2'd2
  } req_id_e;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Keep only the lowest (len+1) bytes, zero-extended.
  function automatic word_t mask_by_len(input word_t w, input logic [1:0] len);
    case (len)
      LEN_B:   return {24'h0, w[7:0]};
      LEN_H:   return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One requester's pending flag plus its captured addr/len/data; a new capture beats a clear.
module mem_req_slot
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       capture,
  input  logic       clear,
  input  addr_t      addr_in,
  input  logic [1:0] len_in,
  input  word_t      data_in,
  output logic       pending,
  output addr_t      addr,
  output logic [1:0] len,
  output word_t      data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      addr    <= '0;
      len     <= '0;
      data    <= '0;
    end else if (rdy) begin
      if (capture) begin
        pending <= 1'b1;
        addr    <= addr_in;
        len     <= len_in;
        data    <= data_in;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF / LB / ST requests onto one memory command port and routes completions back.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AGE_LIMIT = 4,
  parameter int unsigned AGE_W     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear_flag_in,
  input  logic        if_fetch_enable_in,
  input  logic [31:0] if_addr_in,
  output logic        if_result_enable_out,
  output logic [31:0] if_data_out,
  input  logic        lb_fetch_enable_in,
  input  logic [31:0] lb_addr_in,
  input  logic [1:0]  lb_len_in,
  output logic        lb_result_enable_out,
  output logic [31:0] lb_data_out,
  input  logic        st_store_enable_in,
  input  logic [31:0] st_addr_in,
  input  logic [1:0]  st_len_in,
  input  logic [31:0] st_data_in,
  output logic        st_result_enable_out,
  output logic        mem_req_valid_out,
  output logic        mem_req_write_out,
  output logic [31:0] mem_req_addr_out,
  output logic [1:0]  mem_req_len_out,
  output logic [31:0] mem_req_data_out,
  input  logic        mem_done_in,
  input  logic [31:0] mem_rdata_in
);

  state_e         state;
  req_id_e        owner;
  logic           discard;
  logic [AGE_W-1:0] age_cnt;
  word_t          rdata_q;

  logic           if_pend, lb_pend, st_pend;
  addr_t          if_addr, lb_addr, st_addr;
  logic [1:0]     if_len, lb_len, st_len;
  word_t          if_data, lb_data, st_data;

  logic           if_live, lb_live, age_promote;
  logic           grant_any;
  req_id_e        grant_id;
  addr_t          sel_addr;
  logic [1:0]     sel_len;
  word_t          sel_data;
  logic           flush_owner;

  // A flush hides speculative pending work from the same-cycle grant decision.
  assign if_live     = if_pend & ~clear_flag_in;
  assign lb_live     = lb_pend & ~clear_flag_in;
  assign age_promote = (age_cnt >= AGE_W'(AGE_LIMIT));
  assign flush_owner = clear_flag_in && (owner != REQ_ST);

  mem_req_slot u_if_slot (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .capture (if_fetch_enable_in & ~clear_flag_in),
    .clear   ((grant_any && grant_id == REQ_IF) || clear_flag_in),
    .addr_in (if_addr_in),
    .len_in  (LEN_W),
    .data_in ('0),
    .pending (if_pend),
    .addr    (if_addr),
    .len     (if_len),
    .data    (if_data)
  );

  mem_req_slot u_lb_slot (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .capture (lb_fetch_enable_in & ~clear_flag_in),
    .clear   ((grant_any && grant_id == REQ_LB) || clear_flag_in),
    .addr_in (lb_addr_in),
    .len_in  (lb_len_in),
    .data_in ('0),
    .pending (lb_pend),
    .addr    (lb_addr),
    .len     (lb_len),
    .data    (lb_data)
  );

  mem_req_slot u_st_slot (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .capture (st_store_enable_in),
    .clear   (grant_any && grant_id == REQ_ST),
    .addr_in (st_addr_in),
    .len_in  (st_len_in),
    .data_in (st_data_in),
    .pending (st_pend),
    .addr    (st_addr),
    .len     (st_len),
    .data    (st_data)
  );

  always_comb begin
    grant_any = 1'b0;
    grant_id  = REQ_IF;
    if (state == S_IDLE) begin
      if (if_live && age_promote) begin
        grant_any = 1'b1;
        grant_id  = REQ_IF;
      end else if (st_pend) begin
        grant_any = 1'b1;
        grant_id  = REQ_ST;
      end else if (lb_live) begin
        grant_any = 1'b1;
        grant_id  = REQ_LB;
      end else if (if_live) begin
        grant_any = 1'b1;
        grant_id  = REQ_IF;
      end
    end
  end

  always_comb begin
    sel_addr = if_addr;
    sel_len  = if_len;
    sel_data = if_data;
    case (grant_id)
      REQ_LB: begin
        sel_addr = lb_addr;
        sel_len  = lb_len;
        sel_data = lb_data;
      end
      REQ_ST: begin
        sel_addr = st_addr;
        sel_len  = st_len;
        sel_data = st_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_cnt <= '0;
    end else if (rdy) begin
      if (!if_live)
        age_cnt <= '0;
      else if (grant_any)
        age_cnt <= (grant_id == REQ_IF) ? '0 : (age_promote ? age_cnt : age_cnt + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      owner                <= REQ_IF;
      discard              <= 1'b0;
      rdata_q              <= '0;
      mem_req_valid_out    <= 1'b0;
      mem_req_write_out    <= 1'b0;
      mem_req_addr_out     <= '0;
      mem_req_len_out      <= '0;
      mem_req_data_out     <= '0;
      if_result_enable_out <= 1'b0;
      lb_result_enable_out <= 1'b0;
      st_result_enable_out <= 1'b0;
      if_data_out          <= '0;
      lb_data_out          <= '0;
    end else if (rdy) begin
      mem_req_valid_out    <= 1'b0;
      if_result_enable_out <= 1'b0;
      lb_result_enable_out <= 1'b0;
      st_result_enable_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            state             <= S_WAIT;
            owner             <= grant_id;
            discard           <= 1'b0;
            mem_req_valid_out <= 1'b1;
            mem_req_write_out <= (grant_id == REQ_ST);
            mem_req_addr_out  <= sel_addr;
            mem_req_len_out   <= sel_len;
            mem_req_data_out  <= sel_data;
          end
        end
        S_WAIT: begin
          if (flush_owner)
            discard <= 1'b1;
          // A squashed transaction still drains the downstream done, then skips RESP.
          if (mem_done_in) begin
            rdata_q <= mem_rdata_in;
            if (discard || flush_owner) begin
              state   <= S_IDLE;
              discard <= 1'b0;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          if (!flush_owner) begin
            case (owner)
              REQ_IF: begin
                if_result_enable_out <= 1'b1;
                if_data_out          <= rdata_q;
              end
              REQ_LB: begin
                lb_result_enable_out <= 1'b1;
                lb_data_out          <= mask_by_len(rdata_q, mem_req_len_out);
              end
              default: st_result_enable_out <= 1'b1;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk, rst, rdy, clear_flag_in;
  logic        if_fetch_enable_in;
  logic [31:0] if_addr_in;
  logic        if_result_enable_out;
  logic [31:0] if_data_out;
  logic        lb_fetch_enable_in;
  logic [31:0] lb_addr_in;
  logic [1:0]  lb_len_in;
  logic        lb_result_enable_out;
  logic [31:0] lb_data_out;
  logic        st_store_enable_in;
  logic [31:0] st_addr_in;
  logic [1:0]  st_len_in;
  logic [31:0] st_data_in;
  logic        st_result_enable_out;
  logic        mem_req_valid_out, mem_req_write_out;
  logic [31:0] mem_req_addr_out;
  logic [1:0]  mem_req_len_out;
  logic [31:0] mem_req_data_out;
  logic        mem_done_in;
  logic [31:0] mem_rdata_in;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AGE_LIMIT(4), .AGE_W(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rdy                  (rdy),
    .clear_flag_in        (clear_flag_in),
    .if_fetch_enable_in   (if_fetch_enable_in),
    .if_addr_in           (if_addr_in),
    .if_result_enable_out (if_result_enable_out),
    .if_data_out          (if_data_out),
    .lb_fetch_enable_in   (lb_fetch_enable_in),
    .lb_addr_in           (lb_addr_in),
    .lb_len_in            (lb_len_in),
    .lb_result_enable_out (lb_result_enable_out),
    .lb_data_out          (lb_data_out),
    .st_store_enable_in   (st_store_enable_in),
    .st_addr_in           (st_addr_in),
    .st_len_in            (st_len_in),
    .st_data_in           (st_data_in),
    .st_result_enable_out (st_result_enable_out),
    .mem_req_valid_out    (mem_req_valid_out),
    .mem_req_write_out    (mem_req_write_out),
    .mem_req_addr_out     (mem_req_addr_out),
    .mem_req_len_out      (mem_req_len_out),
    .mem_req_data_out     (mem_req_data_out),
    .mem_done_in          (mem_done_in),
    .mem_rdata_in         (mem_rdata_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Done pulse for one cycle, then one more cycle: result pulse is visible on return.
  task automatic finish_txn(input logic [31:0] d);
    mem_done_in  = 1'b1;
    mem_rdata_in = d;
    tick();
    mem_done_in  = 1'b0;
    mem_rdata_in = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear_flag_in = 1'b0;
    if_fetch_enable_in = 1'b0; if_addr_in = '0;
    lb_fetch_enable_in = 1'b0; lb_addr_in = '0; lb_len_in = '0;
    st_store_enable_in = 1'b0; st_addr_in = '0; st_len_in = '0; st_data_in = '0;
    mem_done_in = 1'b0; mem_rdata_in = '0;
    tick(); tick();
    rst = 1'b0;

    chk1("rst_valid", mem_req_valid_out, 1'b0);
    chk1("rst_write", mem_req_write_out, 1'b0);
    chkw("rst_addr", mem_req_addr_out, 32'h0);
    chkw("rst_len", 32'(mem_req_len_out), 32'h0);
    chkw("rst_data", mem_req_data_out, 32'h0);
    chk1("rst_if_res", if_result_enable_out, 1'b0);
    chk1("rst_lb_res", lb_result_enable_out, 1'b0);
    chk1("rst_st_res", st_result_enable_out, 1'b0);
    chkw("rst_if_data", if_data_out, 32'h0);
    chkw("rst_lb_data", lb_data_out, 32'h0);

    // Single IF fetch
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h0000_1000;
    tick();
    if_fetch_enable_in = 1'b0;
    chk1("t1_no_early_cmd", mem_req_valid_out, 1'b0);
    tick();
    chk1("t1_valid", mem_req_valid_out, 1'b1);
    chk1("t1_write", mem_req_write_out, 1'b0);
    chkw("t1_len", 32'(mem_req_len_out), 32'd3);
    chkw("t1_addr", mem_req_addr_out, 32'h0000_1000);
    tick();
    chk1("t1_valid_one_cycle", mem_req_valid_out, 1'b0);
    tick(); tick(); tick();
    mem_done_in = 1'b1; mem_rdata_in = 32'hCAFE_F00D;
    tick();
    mem_done_in = 1'b0; mem_rdata_in = '0;
    chk1("t1_res_not_yet", if_result_enable_out, 1'b0);
    tick();
    chk1("t1_if_res", if_result_enable_out, 1'b1);
    chkw("t1_if_data", if_data_out, 32'hCAFE_F00D);
    tick();
    chk1("t1_if_res_one_cycle", if_result_enable_out, 1'b0);

    // Simultaneous ST, LB, IF
    st_store_enable_in = 1'b1; st_addr_in = 32'h2000; st_len_in = 2'd3; st_data_in = 32'h1122_3344;
    lb_fetch_enable_in = 1'b1; lb_addr_in = 32'h3001; lb_len_in = 2'd0;
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h1004;
    tick();
    st_store_enable_in = 1'b0; lb_fetch_enable_in = 1'b0; if_fetch_enable_in = 1'b0;
    tick();
    chk1("t2_st_valid", mem_req_valid_out, 1'b1);
    chk1("t2_st_write", mem_req_write_out, 1'b1);
    chkw("t2_st_addr", mem_req_addr_out, 32'h2000);
    chkw("t2_st_data", mem_req_data_out, 32'h1122_3344);
    finish_txn(32'h0);
    chk1("t2_st_res", st_result_enable_out, 1'b1);
    chk1("t2_no_cmd_during_res", mem_req_valid_out, 1'b0);
    tick();
    chk1("t2_lb_valid", mem_req_valid_out, 1'b1);
    chkw("t2_lb_addr", mem_req_addr_out, 32'h3001);
    chk1("t2_lb_write", mem_req_write_out, 1'b0);
    chkw("t2_lb_len", 32'(mem_req_len_out), 32'd0);
    finish_txn(32'hDEAD_BEEF);
    chk1("t2_lb_res", lb_result_enable_out, 1'b1);
    chkw("t2_lb_byte", lb_data_out, 32'h0000_00EF);
    tick();
    chk1("t2_if_valid", mem_req_valid_out, 1'b1);
    chkw("t2_if_addr", mem_req_addr_out, 32'h1004);
    finish_txn(32'h600D_0001);
    chk1("t2_if_res", if_result_enable_out, 1'b1);
    chkw("t2_if_data", if_data_out, 32'h600D_0001);

    // LB halfword
    tick();
    lb_fetch_enable_in = 1'b1; lb_addr_in = 32'h3002; lb_len_in = 2'd1;
    tick();
    lb_fetch_enable_in = 1'b0;
    tick();
    chkw("t3_lb_addr", mem_req_addr_out, 32'h3002);
    finish_txn(32'hDEAD_BEEF);
    chk1("t3_lb_res", lb_result_enable_out, 1'b1);
    chkw("t3_lb_half", lb_data_out, 32'h0000_BEEF);

    // Flush during LB WAIT with IF pending
    tick();
    lb_fetch_enable_in = 1'b1; lb_addr_in = 32'h4000; lb_len_in = 2'd3;
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h1008;
    tick();
    lb_fetch_enable_in = 1'b0; if_fetch_enable_in = 1'b0;
    tick();
    chkw("t4_lb_first", mem_req_addr_out, 32'h4000);
    tick();
    clear_flag_in = 1'b1;
    tick();
    clear_flag_in = 1'b0;
    chk1("t4_no_cmd_after_clear", mem_req_valid_out, 1'b0);
    tick(); tick();
    chk1("t4_still_waiting", mem_req_valid_out, 1'b0);
    mem_done_in = 1'b1; mem_rdata_in = 32'h1234_5678;
    tick();
    mem_done_in = 1'b0; mem_rdata_in = '0;
    chk1("t4_no_lb_res_a", lb_result_enable_out, 1'b0);
    chk1("t4_no_if_res_a", if_result_enable_out, 1'b0);
    tick();
    chk1("t4_no_lb_res_b", lb_result_enable_out, 1'b0);
    chk1("t4_no_if_res_b", if_result_enable_out, 1'b0);
    chk1("t4_if_dropped_a", mem_req_valid_out, 1'b0);
    tick();
    chk1("t4_if_dropped_b", mem_req_valid_out, 1'b0);
    st_store_enable_in = 1'b1; st_addr_in = 32'h4800; st_len_in = 2'd3; st_data_in = 32'h0F0F_0F0F;
    tick();
    st_store_enable_in = 1'b0;
    tick();
    chk1("t4_next_valid", mem_req_valid_out, 1'b1);
    chkw("t4_next_addr", mem_req_addr_out, 32'h4800);
    finish_txn(32'h0);
    chk1("t4_st_res", st_result_enable_out, 1'b1);

    // Flush during ST WAIT plus same-cycle ST pulse
    tick();
    st_store_enable_in = 1'b1; st_addr_in = 32'h5000; st_len_in = 2'd3; st_data_in = 32'hAAAA_5555;
    tick();
    st_store_enable_in = 1'b0;
    tick();
    chkw("t5_st1_addr", mem_req_addr_out, 32'h5000);
    tick();
    clear_flag_in = 1'b1;
    st_store_enable_in = 1'b1; st_addr_in = 32'h5004; st_len_in = 2'd1; st_data_in = 32'h1234_5678;
    tick();
    clear_flag_in = 1'b0; st_store_enable_in = 1'b0;
    chk1("t5_no_cmd", mem_req_valid_out, 1'b0);
    finish_txn(32'h0);
    chk1("t5_st1_res", st_result_enable_out, 1'b1);
    tick();
    chk1("t5_st1_res_once", st_result_enable_out, 1'b0);
    chk1("t5_st2_valid", mem_req_valid_out, 1'b1);
    chkw("t5_st2_addr", mem_req_addr_out, 32'h5004);
    chkw("t5_st2_data", mem_req_data_out, 32'h1234_5678);
    chkw("t5_st2_len", 32'(mem_req_len_out), 32'd1);
    finish_txn(32'h0);
    chk1("t5_st2_res", st_result_enable_out, 1'b1);

    // Aging: IF pending while LB keeps winning
    tick();
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h1100;
    lb_fetch_enable_in = 1'b1; lb_addr_in = 32'h6000; lb_len_in = 2'd3;
    tick();
    if_fetch_enable_in = 1'b0; lb_fetch_enable_in = 1'b0;
    tick();
    chkw("t6_lb_grant1", mem_req_addr_out, 32'h6000);
    for (int k = 2; k <= 4; k++) begin
      lb_fetch_enable_in = 1'b1; lb_addr_in = 32'h6000 + 32'(4 * k);
      tick();
      lb_fetch_enable_in = 1'b0;
      finish_txn(32'h100 + 32'(k));
      chk1("t6_lb_res", lb_result_enable_out, 1'b1);
      chkw("t6_lb_data", lb_data_out, 32'h100 + 32'(k));
      tick();
      chkw("t6_lb_grant", mem_req_addr_out, 32'h6000 + 32'(4 * k));
    end
    lb_fetch_enable_in = 1'b1; lb_addr_in = 32'h6040;
    tick();
    lb_fetch_enable_in = 1'b0;
    finish_txn(32'h200);
    chk1("t6_lb4_res", lb_result_enable_out, 1'b1);
    tick();
    chk1("t6_if_promoted_valid", mem_req_valid_out, 1'b1);
    chkw("t6_if_promoted_addr", mem_req_addr_out, 32'h1100);

    // rdy low for 3 cycles mid-WAIT, with a done pulse that must be ignored
    rdy = 1'b0;
    mem_done_in = 1'b1; mem_rdata_in = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("t7_frozen_valid", mem_req_valid_out, 1'b1);
      chkw("t7_frozen_addr", mem_req_addr_out, 32'h1100);
      chk1("t7_frozen_if_res", if_result_enable_out, 1'b0);
    end
    rdy = 1'b1;
    mem_done_in = 1'b0; mem_rdata_in = '0;
    tick();
    chk1("t7_valid_drops", mem_req_valid_out, 1'b0);
    chk1("t7_done_ignored", if_result_enable_out, 1'b0);
    finish_txn(32'h0BAD_F00D);
    chk1("t7_if_res", if_result_enable_out, 1'b1);
    chkw("t7_if_data", if_data_out, 32'h0BAD_F00D);
    tick();
    chkw("t7_lb_after", mem_req_addr_out, 32'h6040);
    finish_txn(32'h33);
    chk1("t7_lb_res", lb_result_enable_out, 1'b1);
    chkw("t7_lb_data", lb_data_out, 32'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory-controller request port between three requesters: instruction fetcher (IF), load buffer (LB) and commit-side store path (ST).
- Latches each one-cycle request pulse, picks one pending request per transaction, and issues it downstream as a single-cycle command. It then waits for completion and routes the result back to the owning requester.
- Handles pipeline flush: speculative work is squashed, committed stores are preserved.

Parameters:
- AGE_LIMIT, 4, consecutive grants lost by a pending IF request before IF is promoted to top priority for one grant.
- AGE_W, 3, width of the IF aging counter; must satisfy 2^AGE_W > AGE_LIMIT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready; when low, all state and outputs hold
- clear_flag_in  in  1  pipeline flush
- if_fetch_enable_in  in  1  IF request pulse
- if_addr_in  in  32  IF word address
- if_result_enable_out  out  1  IF data-valid pulse
- if_data_out  out  32  fetched word
- lb_fetch_enable_in  in  1  load request pulse
- lb_addr_in  in  32  load address
- lb_len_in  in  2  load length: 0 = byte, 1 = halfword, 3 = word
- lb_result_enable_out  out  1  load data-valid pulse
- lb_data_out  out  32  loaded data, zero-extended, little-endian
- st_store_enable_in  in  1  store request pulse
- st_addr_in  in  32  store address
- st_len_in  in  2  store length: 0, 1 or 3
- st_data_in  in  32  store data
- st_result_enable_out  out  1  store-done pulse
- mem_req_valid_out  out  1  downstream command pulse
- mem_req_write_out  out  1  1 = write, 0 = read
- mem_req_addr_out  out  32  command address
- mem_req_len_out  out  2  command length
- mem_req_data_out  out  32  write data
- mem_done_in  in  1  downstream completion pulse
- mem_rdata_in  in  32  read data, valid while mem_done_in is high

Behaviour:
- Reset (asynchronous): every output, every pending flag, the aging counter and the discard flag go to 0; state goes to IDLE.
- rdy low: the block holds completely; no latching, no state change, outputs keep their values.
- Capture: a request pulse at cycle N sets the requester's pending flag and copies its addr/len/data into that requester's private slot at edge N.
- A new pulse from a requester whose slot is already pending overwrites the slot. This is a protocol violation; requesters must wait for their result pulse before requesting again.
- FSM states:
  - IDLE: if any request is pending, grant one. At that edge, drive mem_req_* from the granted slot, pulse mem_req_valid_out for one cycle, clear the granted pending flag, record the owner, and move to WAIT.
  - WAIT: on mem_done_in, move to RESP. Downstream data for a read is captured on the mem_done_in cycle.
  - RESP: pulse the owner's result_enable for one cycle, with data valid in that same cycle; move to IDLE.
- Minimum latency: request pulse at N, mem_req_valid_out at N+1, result pulse two cycles after mem_done_in.
- A pulse arriving in the same cycle as an IDLE grant is latched; it is arbitrated in the next IDLE.
- Priority order: ST, then LB, then IF.
- Aging: the IF aging counter increments each time a grant goes elsewhere while IF is pending. When the counter reaches AGE_LIMIT, IF takes top priority for the next grant. The counter clears on every IF grant and whenever IF is not pending.
- clear_flag_in (takes priority over all same-cycle inputs):
  - IF and LB pending flags are cleared; the ST pending flag and slot are kept.
  - If the outstanding owner is IF or LB, the discard flag is set. The FSM still waits for mem_done_in, then returns to IDLE without any result pulse.
  - If the outstanding owner is ST, it completes normally.
  - A clear during RESP for IF or LB suppresses that pulse.
  - Request pulses arriving in the same cycle as clear_flag_in are dropped, except a ST pulse, which is latched.
- mem_done_in while in IDLE or RESP is ignored.
- lb_data_out: only the lowest (len+1) bytes of mem_rdata_in are kept; upper bytes are zero.

Decomposition:
- Shared defines file: requester IDs (REQ_IF, REQ_LB, REQ_ST), the length codes (LEN_B = 0, LEN_H = 1, LEN_W = 3) and FSM state encodings. Reuse the existing AddrType and WordType macros.
- One natural sub-module: mem_req_slot (pending flag plus addr/len/data register with capture and clear), instantiated three times.

Test Plan:
- Single IF at 0x00001000, downstream done 5 cycles after command -> mem_req_valid_out with write = 0, len = 3, addr 0x1000; if_result_enable_out one pulse, two cycles after done, with data = mem_rdata_in.
- ST, LB and IF pulses in the same cycle -> grants in order ST, LB, IF; each result pulse precedes the next mem_req_valid_out.
- LB byte load, mem_rdata_in = 0xDEADBEEF -> lb_data_out = 0x000000EF; halfword load -> 0x0000BEEF.
- Clear while an LB read is in WAIT and IF is pending -> no LB or IF result pulse; next command only after the done pulse; IF pending is cleared.
- Clear while a ST is in WAIT, plus a same-cycle ST pulse -> first store completes with one pulse, the second store is then issued.
- Back-to-back LB requests with IF pending and AGE_LIMIT = 4 -> IF granted after the 4th LB grant; rdy low for 3 cycles mid-WAIT -> all outputs frozen.
